alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// UART command sequencer: parses opcode/len packets, echoes payload bytes or
// chains 32-bit operands through an external ALU and returns the result.
module alu_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 25000000,
    parameter int unsigned MAX_LEN        = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        alu_req_o,
    output logic [1:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic        alu_ack_i,
    input  logic [31:0] alu_result_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        err_o
);
    typedef enum logic [2:0] {IDLE, HDR, ECHO, OPERAND, WAIT_ACK, SEND, DISCARD} state_t;

    localparam logic [7:0] OPC_ECHO = 8'hEC;
    localparam logic [7:0] OPC_ADD  = 8'hAD;
    localparam logic [7:0] OPC_MUL  = 8'h88;
    localparam logic [7:0] OPC_DIV  = 8'hDD;

    state_t      state_q, state_d;
    logic [7:0]  opc_q, opc_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] sh_q, sh_d;
    logic [31:0] b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic        req_q, req_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic [2:0]  sidx_q, sidx_d;
    logic        err_q, err_d;

    logic [15:0] hdr_len;
    logic [31:0] opnd;
    logic        last_byte, timed, len_ok, is_alu, alu_ok;
    logic [1:0]  hdr_op;
    logic [7:0]  acc_byte;

    assign hdr_len   = {rx_data_i, len_q[7:0]};
    assign opnd      = {rx_data_i, sh_q[31:8]};
    assign last_byte = (cnt_q + 16'd1) == len_q;
    assign len_ok    = (hdr_len >= 16'd4) && ({16'd0, hdr_len} <= MAX_LEN);
    assign alu_ok    = is_alu && len_ok && (hdr_len[1:0] == 2'b00) && (hdr_len >= 16'd12);
    assign timed     = (state_q == HDR) || (state_q == ECHO) ||
                       (state_q == OPERAND) || (state_q == DISCARD);

    always_comb begin
        is_alu = 1'b1;
        hdr_op = 2'd0;
        case (opc_q)
            OPC_ADD: hdr_op = 2'd0;
            OPC_MUL: hdr_op = 2'd1;
            OPC_DIV: hdr_op = 2'd2;
            default: is_alu = 1'b0;
        endcase
    end

    always_comb begin
        case (sidx_q[1:0])
            2'd0:    acc_byte = acc_q[7:0];
            2'd1:    acc_byte = acc_q[15:8];
            2'd2:    acc_byte = acc_q[23:16];
            default: acc_byte = acc_q[31:24];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        tmo_d      = '0;
        sh_d       = sh_q;
        b_d        = b_q;
        acc_d      = acc_q;
        req_d      = req_q;
        op_d       = op_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q & ~tx_ready_i;
        sidx_d     = sidx_q;
        err_d      = 1'b0;

        // an ack only counts against a live request
        if (req_q && alu_ack_i) begin
            req_d = 1'b0;
            acc_d = alu_result_i;
        end
        if (timed && !rx_valid_i) tmo_d = tmo_q + 32'd1;

        case (state_q)
            IDLE: if (rx_valid_i) begin
                opc_d   = rx_data_i;
                cnt_d   = 16'd1;
                state_d = HDR;
            end
            HDR: if (rx_valid_i) begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd2) len_d[7:0] = rx_data_i;
                if (cnt_q == 16'd3) begin
                    len_d = hdr_len;
                    if (opc_q == OPC_ECHO && len_ok) begin
                        state_d = (hdr_len == 16'd4) ? IDLE : ECHO;
                    end else if (alu_ok) begin
                        op_d    = hdr_op;
                        state_d = OPERAND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = (len_ok && hdr_len != 16'd4) ? DISCARD : IDLE;
                    end
                end
            end
            ECHO: if (rx_valid_i) begin
                cnt_d = cnt_q + 16'd1;
                if (hold_vld_q && !tx_ready_i) begin
                    err_d = 1'b1;
                end else begin
                    hold_d     = rx_data_i;
                    hold_vld_d = 1'b1;
                end
                if (last_byte) state_d = IDLE;
            end
            OPERAND: if (rx_valid_i) begin
                cnt_d = cnt_q + 16'd1;
                sh_d  = opnd;
                if (cnt_q[1:0] == 2'd3) begin
                    if (cnt_q == 16'd7) begin
                        acc_d = opnd;
                    end else if (req_q && !alu_ack_i) begin
                        // ALU too slow for the byte stream: drop the packet
                        err_d   = 1'b1;
                        state_d = last_byte ? IDLE : DISCARD;
                    end else begin
                        b_d   = opnd;
                        req_d = 1'b1;
                        if (last_byte) state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (rx_valid_i) err_d = 1'b1;
                if (req_q && alu_ack_i) begin
                    sidx_d  = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (rx_valid_i) err_d = 1'b1;
                if (!hold_vld_q || tx_ready_i) begin
                    if (sidx_q < 3'd4) begin
                        hold_d     = acc_byte;
                        hold_vld_d = 1'b1;
                        sidx_d     = sidx_q + 3'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: if (rx_valid_i) begin
                cnt_d = cnt_q + 16'd1;
                if (last_byte) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (timed && !rx_valid_i && tmo_q == TIMEOUT_CYCLES - 1) begin
            err_d      = 1'b1;
            state_d    = IDLE;
            hold_vld_d = 1'b0;
            req_d      = 1'b0;
            tmo_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            opc_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            sh_q       <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            req_q      <= 1'b0;
            op_q       <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            sidx_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            sh_q       <= sh_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            req_q      <= req_d;
            op_q       <= op_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            sidx_q     <= sidx_d;
            err_q      <= err_d;
        end
    end

    assign alu_req_o  = req_q;
    assign alu_op_o   = op_q;
    assign alu_a_o    = acc_q;
    assign alu_b_o    = b_q;
    assign tx_valid_o = hold_vld_q;
    assign tx_data_o  = hold_q;
    assign busy_o     = (state_q != IDLE);
    assign err_o      = err_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: packet vector table with tx/ALU scoreboards,
// plus timeout and mid-transaction reset sequences.
module tb_alu_cmd_sequencer;
    localparam int TMO  = 100;
    localparam int MAXL = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        alu_req_o;
    logic [1:0]  alu_op_o;
    logic [31:0] alu_a_o, alu_b_o;
    logic        alu_ack_i = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i = 1'b1;
    logic        busy_o, err_o;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .alu_req_o(alu_req_o), .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_ack_i(alu_ack_i), .alu_result_i(alu_result_i),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct packed { logic [1:0] op; logic [31:0] a; logic [31:0] b; } req_t;

    typedef struct {
        string            nm;
        logic [0:15][7:0] pk;
        int               n;
        int               rdy;   // 0 ready, 1 toggling, 2 stalled while packet is sent
        int               ackd;
        logic [31:0]      tx;    // expected tx bytes, first byte in [7:0]
        int               ntx;
        int               nreq;
        logic [1:0]       op;
        logic [31:0]      a0, b0, a1, b1;
        int               errs;
    } vec_t;

    int          n_err = 0, n_chk = 0;
    int          err_cnt = 0, hold_viol = 0, stab_viol = 0;
    int          rdy_mode = 0, ack_dly = 3, dly = 0;
    logic [7:0]  exp_tx[$], obs_tx[$];
    req_t        exp_rq[$], obs_rq[$];
    logic        m_pr = 0, m_ptv = 0, m_ptr = 0;
    logic [7:0]  m_pd = '0;
    req_t        m_cap = '0;
    vec_t        vt[14];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a * b;
            default: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        endcase
    endfunction

    function automatic vec_t mk(input string nm, input logic [127:0] pk, input int n, input int rdy,
                                input int ackd, input logic [31:0] tx, input int ntx, input int nreq,
                                input logic [1:0] op, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] a1, input logic [31:0] b1, input int errs);
        vec_t v;
        v.nm = nm; v.pk = pk << (8 * (16 - n)); v.n = n; v.rdy = rdy; v.ackd = ackd;
        v.tx = tx; v.ntx = ntx; v.nreq = nreq; v.op = op;
        v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1; v.errs = errs;
        return v;
    endfunction

    // tx_ready pattern and ALU responder, both driven just after the clock edge
    initial forever begin
        @(posedge clk); #1;
        tx_ready_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ~tx_ready_i : 1'b0;
    end

    initial forever begin
        @(posedge clk); #1;
        alu_ack_i = 1'b0;
        if (alu_req_o && rst) begin
            if (dly >= ack_dly - 1) begin
                alu_ack_i    = 1'b1;
                alu_result_i = alu_model(alu_op_o, alu_a_o, alu_b_o);
                dly = 0;
            end else dly++;
        end else dly = 0;
    end

    // observer: records DUT outputs for the main process to score
    initial forever begin
        @(negedge clk);
        if (err_o) err_cnt++;
        if (tx_valid_o && tx_ready_i) obs_tx.push_back(tx_data_o);
        if (rst && m_ptv && !m_ptr && (!tx_valid_o || tx_data_o !== m_pd)) hold_viol++;
        if (alu_req_o && !m_pr) begin
            m_cap = {alu_op_o, alu_a_o, alu_b_o};
            obs_rq.push_back(m_cap);
        end else if (alu_req_o && m_pr && {alu_op_o, alu_a_o, alu_b_o} !== m_cap) stab_viol++;
        m_pr = alu_req_o; m_ptv = tx_valid_o; m_ptr = tx_ready_i; m_pd = tx_data_o;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        @(posedge clk); #1;
        rx_valid_i = 1'b1; rx_data_i = b;
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        int quiet = 0;
        int k = 0;
        while (quiet < 4 && k < 400) begin
            @(negedge clk); k++;
            if (!busy_o && !tx_valid_o && !alu_req_o) quiet++; else quiet = 0;
        end
        chk({nm, "_drain"}, (quiet >= 4), 1);
    endtask

    task automatic score(input string nm);
        req_t e, o;
        logic [7:0] t, u;
        chk({nm, "_tx_count"}, obs_tx.size(), exp_tx.size());
        while (exp_tx.size() > 0 && obs_tx.size() > 0) begin
            t = exp_tx.pop_front(); u = obs_tx.pop_front();
            chk({nm, "_tx_byte"}, u, t);
        end
        chk({nm, "_req_count"}, obs_rq.size(), exp_rq.size());
        while (exp_rq.size() > 0 && obs_rq.size() > 0) begin
            e = exp_rq.pop_front(); o = obs_rq.pop_front();
            chk({nm, "_req_op"}, o.op, e.op);
            chk({nm, "_req_a"}, o.a, e.a);
            chk({nm, "_req_b"}, o.b, e.b);
        end
        exp_tx.delete(); obs_tx.delete(); exp_rq.delete(); obs_rq.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int e0 = err_cnt, h0 = hold_viol, s0 = stab_viol;
        ack_dly = v.ackd;
        for (int i = 0; i < v.ntx; i++) exp_tx.push_back(v.tx[8*i +: 8]);
        if (v.nreq > 0) exp_rq.push_back({v.op, v.a0, v.b0});
        if (v.nreq > 1) exp_rq.push_back({v.op, v.a1, v.b1});
        rdy_mode = v.rdy;
        for (int i = 0; i < v.n; i++) send_byte(v.pk[i]);
        if (v.rdy == 2) rdy_mode = 0;
        drain(v.nm);
        score(v.nm);
        chk({v.nm, "_err_pulses"}, err_cnt - e0, v.errs);
        chk({v.nm, "_tx_hold"}, hold_viol - h0, 0);
        chk({v.nm, "_req_stable"}, stab_viol - s0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:4][7:0] tb5;
        int errk, e0;
        logic busy99;
        int k;

        vt[0]  = mk("echo",      56'hEC000700_414243, 7, 0, 3, 32'h00434241, 3, 0, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk("add",       96'hAD000C00_05000000_07000000, 12, 0, 3, 32'h0000000C, 4, 1, 2'd0, 5, 7, 0, 0, 0);
        vt[2]  = mk("mul_chain", 128'h88001000_02000000_03000000_04000000, 16, 1, 3, 32'h00000018, 4, 2, 2'd1, 2, 3, 6, 4, 0);
        vt[3]  = mk("div",       96'hDD000C00_64000000_07000000, 12, 0, 3, 32'h0000000E, 4, 1, 2'd2, 100, 7, 0, 0, 0);
        vt[4]  = mk("bad_len",   80'hAD000A00_010203040506, 10, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[5]  = mk("echo_after",40'hEC000500_5A, 5, 0, 3, 32'h0000005A, 1, 0, 0, 0, 0, 0, 0, 0);
        vt[6]  = mk("bad_opc",   48'h55000600_AABB, 6, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[7]  = mk("echo_len4", 32'hEC000400, 4, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[8]  = mk("len_lt4",   32'hEC000200, 4, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[9]  = mk("alu_n1",    64'hAD000800_01000000, 8, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[10] = mk("len_max",   32'hEC000001, 4, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[11] = mk("echo_ovf",  48'hEC000600_1122, 6, 2, 3, 32'h00000011, 1, 0, 0, 0, 0, 0, 0, 1);
        vt[12] = mk("alu_ovrun", 128'hAD001000_01000000_02000000_03000000, 16, 0, 40, 0, 0, 1, 2'd0, 1, 2, 0, 0, 1);
        vt[13] = mk("echo_post", 40'hEC000500_77, 5, 0, 3, 32'h00000077, 1, 0, 0, 0, 0, 0, 0, 0);

        #1 rst = 1'b0;
        #2;
        chk("rst_alu_req", alu_req_o, 0);
        chk("rst_tx_valid", tx_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_alu_a", alu_a_o, 0);
        chk("rst_tx_data", tx_data_o, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vt[i]);

        // inter-byte timeout in the middle of an echo payload
        rdy_mode = 0; ack_dly = 3; e0 = err_cnt;
        exp_tx.push_back(8'h41);
        tb5 = {8'hEC, 8'h00, 8'h08, 8'h00, 8'h41};
        for (int i = 0; i < 5; i++) send_byte(tb5[i]);
        errk = -1; busy99 = 1'b0;
        for (int c = 1; c <= 110; c++) begin
            @(posedge clk); @(negedge clk);
            if (err_o && errk < 0) errk = c;
            if (c == 99) busy99 = busy_o;
        end
        chk("tmo_err_cycle", errk, 100);
        chk("tmo_busy_before", busy99, 1);
        chk("tmo_idle_after", busy_o, 0);
        chk("tmo_err_pulses", err_cnt - e0, 1);
        score("tmo");
        run_vec(vt[13]);

        // reset while the add request is outstanding
        ack_dly = 50; rdy_mode = 0;
        exp_rq.push_back({2'd0, 32'd5, 32'd7});
        for (int i = 0; i < 12; i++) send_byte(vt[1].pk[i]);
        k = 0;
        while (!alu_req_o && k < 20) begin @(negedge clk); k++; end
        chk("rst_wait_req", alu_req_o, 1);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("midrst_alu_req", alu_req_o, 0);
        chk("midrst_tx_valid", tx_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_alu_a", alu_a_o, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        score("midrst");
        run_vec(vt[1]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
